move_selector: RTL
==================

MOVE_SELECTOR -- requirements
Module: move_selector

Interface
REQ-001 The block SHALL have parameter CURSOR_INIT, default 6'd12, giving the cursor square after reset (square = row*8+col; row 0 is white's back rank).
REQ-002 The block SHALL have port clk, input, 1, the game clock; the only clock.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports BTNC, BTNU, BTND, BTNR, BTNL, each input, 1, debounced button levels.
REQ-005 The block SHALL have port board, input, 256, the piece nibble of square s at board[4*s+:4]; 0 = empty, bit3 = colour (1 = black).
REQ-006 The block SHALL have port turn, input, 1, side to move (0 = white).
REQ-007 The block SHALL have port move_valid, output, 1, move request to board logic.
REQ-008 The block SHALL have ports move_from and move_to, each output, 6, requested source and destination squares.
REQ-009 The block SHALL have port move_ack, input, 1, one-cycle completion pulse from board logic.
REQ-010 The block SHALL have port move_ok, input, 1, qualifier of move_ack (1 = accepted).
REQ-011 The block SHALL have port moveData, output, 14, {phase[1:0], src[5:0], cursor[5:0]} for the display.

Function
REQ-012 Each button SHALL be rising-edge detected; the press acts in the cycle after the edge is detected, exactly once per press.
REQ-013 Direction presses SHALL move the cursor in all phases except COMMIT: U = row+1, D = row-1, R = col+1, L = col-1, each wrapping modulo 8 within its axis.
REQ-014 Simultaneous direction edges SHALL apply only the highest-priority one (U > D > R > L); the others are discarded.
REQ-015 A direction edge coinciding with a BTNC edge SHALL be discarded, and BTNC SHALL act on the pre-move cursor.
REQ-016 The FSM SHALL have states SEL_SRC (phase 00), SEL_DST (phase 01) and COMMIT (phase 10); phase 11 is unused.
REQ-017 In SEL_SRC, BTNC on a non-empty square whose colour equals turn SHALL set src := cursor and enter SEL_DST; any other BTNC SHALL be ignored.
REQ-018 In SEL_DST, BTNC with cursor == src SHALL cancel to SEL_SRC.
REQ-019 In SEL_DST, BTNC on another own-colour piece SHALL reselect src := cursor and stay in SEL_DST.
REQ-020 In SEL_DST, any other BTNC SHALL enter COMMIT.
REQ-021 In COMMIT, move_valid SHALL be 1, move_from = src and move_to = cursor, all held stable; buttons SHALL be ignored, but their edge-detect registers keep tracking.
REQ-022 move_ack with move_ok = 1 in COMMIT SHALL go to SEL_SRC; move_valid SHALL be 0 in the next cycle and the cursor SHALL stay on the destination square.
REQ-023 move_ack with move_ok = 0 in COMMIT SHALL go to SEL_DST with src retained.
REQ-024 move_ack outside COMMIT SHALL be ignored.
REQ-025 move_valid SHALL be registered and asserted the cycle the FSM enters COMMIT (2 cycles after the BTNC edge on the input).
REQ-026 moveData SHALL be registered and reflect the current state, src and cursor every cycle.

Reset
REQ-027 While reset is low: phase = SEL_SRC, src = 0, cursor = CURSOR_INIT, move_valid = 0, move_from = 0, move_to = 0, moveData = {2'b00, 6'd0, CURSOR_INIT}.
REQ-028 Edge-detect history registers SHALL reset to 1, so a button held through reset release produces no press.
REQ-029 Reset asserted mid-COMMIT SHALL drop move_valid immediately (asynchronously).

Structure
REQ-030 Piece nibble encoding, colour bit position, phase codes and the square-index formula SHALL live in shared package chess_pkg, together with the board-logic block.
REQ-031 One sub-module, btn_edge (registered rising-edge detector with reset-to-1 history), SHALL be instantiated once per button.

Verification
REQ-032 Reset, then 3 U presses and 2 R presses -> moveData[5:0] = 38 (row 4, col 6); L press at col 0 -> col 7; D press at row 0 -> row 7.
REQ-033 turn = 0 with a white pawn (0x1) at square 12: BTNC -> phase 01, src = 12; U, U, BTNC -> move_valid = 1, move_from = 12, move_to = 28, held until move_ack.
REQ-034 In COMMIT, move_ack = 1 with move_ok = 0 -> phase 01, src = 12, move_valid = 0; then move_ack = 1 with move_ok = 1 from a fresh COMMIT -> phase 00, cursor = 28.
REQ-035 BTNC on an empty square, or a black piece while turn = 0 -> phase stays 00; in SEL_DST, BTNC on src -> phase 00.
REQ-036 U and R edges in the same cycle -> only the row changes.
REQ-037 Button held high across reset release -> no cursor change; reset pulse while move_valid = 1 -> move_valid = 0 before the next clk edge.

Source files
------------

// File: rtl/chess_pkg.sv
// rtl/chess_pkg.sv - shared chess encodings for the move selector and board logic
//
// Purpose: single home for the piece nibble layout, colour bit, selector phase
// codes and square indexing so every block agrees on the board format.
// Ports: none (package).
package chess_pkg;

  // Selector phase as shown on the display; 2'b11 is never produced.
  typedef enum logic [1:0] {
    SEL_SRC = 2'b00,
    SEL_DST = 2'b01,
    COMMIT  = 2'b10
  } phase_e;

  localparam int          PIECE_W     = 4;
  localparam logic [3:0]  PIECE_EMPTY = 4'h0;
  localparam int          COLOUR_BIT  = 3;   // 1 = black, 0 = white
  localparam int          BOARD_W     = 64 * PIECE_W;

  // square = row*8 + col, row 0 is white's back rank.
  function automatic logic [5:0] square_idx(input logic [2:0] row, input logic [2:0] col);
    return {row, col};
  endfunction

  function automatic logic [PIECE_W-1:0] piece_at(input logic [BOARD_W-1:0] board,
                                                  input logic [5:0]         sq);
    return board[{sq, 2'b00} +: PIECE_W];
  endfunction

  // A piece belongs to the side to move when present and its colour matches.
  function automatic logic is_own(input logic [PIECE_W-1:0] piece, input logic turn);
    return (piece != PIECE_EMPTY) && (piece[COLOUR_BIT] == turn);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - registered rising-edge detector for one debounced button
//
// Purpose: emits a one-cycle press pulse the cycle after a 0->1 transition.
// Ports:
//   clk   - game clock
//   rst_n - asynchronous active-low reset
//   btn   - debounced button level
//   press - registered one-cycle press pulse
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  logic hist_q, hist_d;
  logic press_q, press_d;

  always_comb begin
    hist_d  = btn;
    press_d = btn & ~hist_q;
  end

  // History resets high so a button held through reset release is not a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q  <= 1'b1;
      press_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/move_selector.sv
// rtl/move_selector.sv - cursor / source / destination selection and move request
//
// Purpose: lets the player walk a cursor over the board with direction buttons,
// pick a source piece and a destination with BTNC, then request the move from
// board logic and wait for its acknowledge.
// Ports:
//   clk                      - game clock
//   reset                    - asynchronous active-low reset
//   BTNC/BTNU/BTND/BTNR/BTNL - debounced button levels
//   board                    - 64 piece nibbles, square s at board[4*s+:4]
//   turn                     - side to move (0 = white)
//   move_valid               - move request, held through COMMIT
//   move_from, move_to       - requested source / destination squares
//   move_ack, move_ok        - completion pulse and accept qualifier
//   moveData                 - {phase, src, cursor} for the display
module move_selector
  import chess_pkg::*;
#(
  parameter logic [5:0] CURSOR_INIT = 6'd12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               BTNC,
  input  logic               BTNU,
  input  logic               BTND,
  input  logic               BTNR,
  input  logic               BTNL,
  input  logic [BOARD_W-1:0] board,
  input  logic               turn,
  output logic               move_valid,
  output logic [5:0]         move_from,
  output logic [5:0]         move_to,
  input  logic               move_ack,
  input  logic               move_ok,
  output logic [13:0]        moveData
);

  logic press_c, press_u, press_d, press_r, press_l;

  btn_edge u_edge_c (.clk(clk), .rst_n(reset), .btn(BTNC), .press(press_c));
  btn_edge u_edge_u (.clk(clk), .rst_n(reset), .btn(BTNU), .press(press_u));
  btn_edge u_edge_d (.clk(clk), .rst_n(reset), .btn(BTND), .press(press_d));
  btn_edge u_edge_r (.clk(clk), .rst_n(reset), .btn(BTNR), .press(press_r));
  btn_edge u_edge_l (.clk(clk), .rst_n(reset), .btn(BTNL), .press(press_l));

  phase_e      state_q, state_d;
  logic [5:0]  src_q, src_d;
  logic [5:0]  cursor_q, cursor_d;
  logic        move_valid_q, move_valid_d;
  logic [5:0]  move_from_q, move_from_d;
  logic [5:0]  move_to_q, move_to_d;
  logic [13:0] move_data_q, move_data_d;

  logic [2:0]  row, col, row_up, row_dn, col_rt, col_lf;
  logic [5:0]  cursor_dir;
  logic        own_here;

  always_comb begin
    row    = cursor_q[5:3];
    col    = cursor_q[2:0];
    row_up = row + 3'd1;
    row_dn = row - 3'd1;
    col_rt = col + 3'd1;
    col_lf = col - 3'd1;

    // Only the highest-priority direction applies: U > D > R > L.
    cursor_dir = cursor_q;
    if (press_u)      cursor_dir = square_idx(row_up, col);
    else if (press_d) cursor_dir = square_idx(row_dn, col);
    else if (press_r) cursor_dir = square_idx(row, col_rt);
    else if (press_l) cursor_dir = square_idx(row, col_lf);

    own_here = is_own(piece_at(board, cursor_q), turn);
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    cursor_d = cursor_q;

    case (state_q)
      SEL_SRC: begin
        if (press_c) begin
          // BTNC wins over any coincident direction and sees the old cursor.
          if (own_here) begin
            src_d   = cursor_q;
            state_d = SEL_DST;
          end
        end else begin
          cursor_d = cursor_dir;
        end
      end
      SEL_DST: begin
        if (press_c) begin
          if (cursor_q == src_q) begin
            state_d = SEL_SRC;
          end else if (own_here) begin
            src_d = cursor_q;
          end else begin
            state_d = COMMIT;
          end
        end else begin
          cursor_d = cursor_dir;
        end
      end
      COMMIT: begin
        if (move_ack) begin
          state_d = move_ok ? SEL_SRC : SEL_DST;
        end
      end
      default: state_d = SEL_SRC;
    endcase

    // Outputs are registered from next-state so they line up with state_q.
    move_valid_d = (state_d == COMMIT);
    move_from_d  = (state_d == COMMIT) ? src_d : 6'd0;
    move_to_d    = (state_d == COMMIT) ? cursor_d : 6'd0;
    move_data_d  = {state_d, src_d, cursor_d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= SEL_SRC;
      src_q        <= 6'd0;
      cursor_q     <= CURSOR_INIT;
      move_valid_q <= 1'b0;
      move_from_q  <= 6'd0;
      move_to_q    <= 6'd0;
      move_data_q  <= {SEL_SRC, 6'd0, CURSOR_INIT};
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      cursor_q     <= cursor_d;
      move_valid_q <= move_valid_d;
      move_from_q  <= move_from_d;
      move_to_q    <= move_to_d;
      move_data_q  <= move_data_d;
    end
  end

  assign move_valid = move_valid_q;
  assign move_from  = move_from_q;
  assign move_to    = move_to_q;
  assign moveData   = move_data_q;

endmodule
